blk_mem_stream_reader: RTL and testbench
========================================

Name: blk_mem_stream_reader

Overview:
- Read-side master for the team's simple dual-port block RAM.
- Drives the RAM's B-port address and captures its registered read data, which is valid one cycle after the address is presented; the RAM B-port has no read enable.
- Given a start address and a beat count, streams the words out on a valid/ready interface with full backpressure and 1 word/cycle sustained throughput.
- Sits between the RAM and downstream SATA framing logic (FIS/data transmit path).

Parameters:
- DATA_WIDTH, 32, RAM word width and output stream width.
- ADDRESS_WIDTH, 9, RAM address width; addresses wrap modulo 2**ADDRESS_WIDTH.
- LEN_WIDTH, 10, width of beat count; max burst is 2**LEN_WIDTH-1 words.

Ports:
- clk  input  1  single clock; RAM B-port clock is tied to this clock.
- rst_n  input  1  asynchronous assert, active-low reset.
- start  input  1  one-cycle request; sampled only when busy=0.
- start_addr  input  ADDRESS_WIDTH  first RAM address of the burst.
- count  input  LEN_WIDTH  number of words to read.
- abort  input  1  cancel the burst in progress.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at burst end (normal, zero-length or abort).
- addrb  output  ADDRESS_WIDTH  RAM B-port address.
- doutb  input  DATA_WIDTH  RAM B-port registered read data.
- o_data  output  DATA_WIDTH  stream data.
- o_valid  output  1  stream valid.
- o_ready  input  1  stream ready.
- o_last  output  1  high with the final beat of a burst.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: busy=0, done=0, o_valid=0, o_last=0, addrb=0, o_data=0.
  - Internal: FIFO empty, pending flag clear, state IDLE.
- States:
  - IDLE: start=1 with count!=0 latches addr=start_addr and remaining=count, then goes to READ. start=1 with count=0 gives done=1 next cycle, stays IDLE, busy stays 0.
  - READ: issue one read per cycle while issue credit exists. Issuing drives addrb=addr for that cycle, increments addr mod 2**ADDRESS_WIDTH, decrements remaining, and sets pending for the next cycle. Goes to DRAIN when remaining reaches 0 after the last issue.
  - DRAIN: waits until pending=0, FIFO empty and the last beat has been accepted. Then done=1 for one cycle and the block returns to IDLE.
- Issue credit: fifo_count + pending - pop < 2, where pop = o_valid & o_ready in the same cycle.
- Capture:
  - In the cycle after an issue (pending=1), doutb is pushed into a 2-entry FIFO at the clock edge.
  - The FIFO never overflows, by construction of the credit rule.
- Output:
  - o_valid = FIFO not empty; o_data = FIFO head.
  - o_last marks the word issued when remaining was 1.
  - o_data/o_last stay stable while o_valid=1 and o_ready=0.
- Latency: start in cycle 0 gives addrb=start_addr in cycle 1, doutb valid in cycle 2, and o_valid=1 with that word in cycle 3.
- Throughput: with o_ready held at 1, one beat per cycle with no bubbles.
- Backpressure: o_ready=0 stops issue within one cycle. At most 2 words are held, and no word is lost or duplicated.
- addrb holds its last issued value when not issuing. A non-issue cycle's read result is ignored.
- start while busy=1 is ignored, with no effect on the current burst.
- Address wrap: start_addr=2**ADDRESS_WIDTH-1, count=2 reads that address then address 0.
- abort while busy: next cycle the FIFO is flushed, pending is cleared, o_valid=0 and done=1, then IDLE. abort in IDLE is ignored.
- done and o_last: o_last is on the beat; done pulses in the cycle after that beat's handshake.
- Reset mid-burst returns all state to reset values immediately; no partial completion is signalled.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE, READ, DRAIN);
  - FIFO depth constant = 2;
  - the credit threshold, derived from the FIFO depth.
- One sub-module, blk_mem_rd_fifo: a 2-entry DATA_WIDTH+1 (data plus last) FIFO with push, pop, flush, count and empty.
- The top level holds the FSM, address and remaining counters, and the pending flag.

Test Plan:
- Basic burst: start_addr=0x010, count=4, o_ready=1, RAM preloaded with mem[a]=a+0x100.
  - o_valid first in cycle 3 after start.
  - Beats 0x110..0x113 on consecutive cycles, o_last on 0x113, done one cycle later.
- Backpressure: count=8, o_ready toggles 1,0,0,1,... pseudo-random.
  - All 8 words arrive in order, none duplicated.
  - o_data stable while stalled; at most 2 reads issued ahead.
- Wrap: ADDRESS_WIDTH=4, start_addr=0xF, count=3 -> addrb sequence 0xF,0x0,0x1; data mem[15],mem[0],mem[1].
- Zero length and busy start:
  - count=0 -> done pulse the next cycle, busy never set, no o_valid.
  - A second start during a count=5 burst -> ignored; exactly 5 beats.
- Abort with full FIFO: o_ready=0 until FIFO holds 2, then abort -> next cycle o_valid=0, done=1, busy=0. A new burst then runs correctly.
- Async reset mid-burst: rst_n low for 1 ns between edges -> outputs go to reset values immediately. A burst after release starts with latency 3.

Source files
------------

// File: rtl/blk_mem_stream_reader_pkg.sv
// Shared types and constants for the block-RAM stream reader and its skid FIFO.
package blk_mem_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  // Words held plus words in flight from the RAM, minus the one leaving, must stay below this.
  localparam int unsigned CREDIT_LIMIT = FIFO_DEPTH;
  localparam int unsigned OCC_W        = FIFO_CNT_W + 1;
  typedef logic [OCC_W-1:0] occ_t;

endpackage

// File: rtl/blk_mem_rd_fifo.sv
// Small FIFO absorbing the RAM's one-cycle read latency so the stream can stall.
module blk_mem_rd_fifo
  import blk_mem_stream_reader_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic [WIDTH-1:0]      o_head,
  output logic [FIFO_CNT_W-1:0] o_count,
  output logic                  o_empty
);

  logic [WIDTH-1:0]      r_mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] r_wr_ptr;
  logic [FIFO_PTR_W-1:0] r_rd_ptr;
  logic [FIFO_CNT_W-1:0] r_count;

  // NOTE: storage is reset (only two entries) so the head, and thus o_data, reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + FIFO_CNT_W'(i_push) - FIFO_CNT_W'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/blk_mem_stream_reader.sv
// Streams a burst of words out of the block RAM B-port onto a valid/ready interface.
module blk_mem_stream_reader
  import blk_mem_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 9,
  parameter int LEN_WIDTH     = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]     count,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0]    doutb,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic                     o_last
);

  state_t                   r_state, w_next_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [ADDRESS_WIDTH-1:0] r_addr_hold;
  logic [LEN_WIDTH-1:0]     r_remaining;
  logic                     r_pending;
  logic                     r_pend_last;
  logic                     r_done;

  logic                     w_issue;
  logic                     w_finish;
  logic                     w_flush;
  logic                     w_pop;
  logic                     w_credit;
  logic                     w_fifo_empty;
  logic [FIFO_CNT_W-1:0]    w_fifo_count;
  logic [DATA_WIDTH:0]      w_fifo_head;

  assign w_pop    = o_valid & o_ready;
  assign w_credit = (occ_t'(w_fifo_count) + occ_t'(r_pending))
                    < (occ_t'(CREDIT_LIMIT) + occ_t'(w_pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_finish     = 1'b0;
    w_flush      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start && count != '0) w_next_state = ST_READ;
        else if (start)           w_finish     = 1'b1;
      end
      ST_READ: begin
        if (abort) begin
          w_next_state = ST_IDLE;
          w_flush      = 1'b1;
          w_finish     = 1'b1;
        end else if (w_credit) begin
          w_issue = 1'b1;
          if (r_remaining == LEN_WIDTH'(1)) w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          w_next_state = ST_IDLE;
          w_flush      = 1'b1;
          w_finish     = 1'b1;
        end else if (!r_pending &&
                     (w_fifo_empty || (w_fifo_count == FIFO_CNT_W'(1) && w_pop))) begin
          // The last beat leaves this cycle, so done lands in the following cycle.
          w_next_state = ST_IDLE;
          w_finish     = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_addr_hold <= '0;
      r_remaining <= '0;
      r_pending   <= 1'b0;
      r_pend_last <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_pending <= w_issue;
      r_done    <= w_finish;
      if (r_state == ST_IDLE && start) begin
        r_addr      <= start_addr;
        r_remaining <= count;
      end else if (w_issue) begin
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
        r_addr_hold <= r_addr;
        r_pend_last <= (r_remaining == LEN_WIDTH'(1));
      end
    end
  end

  blk_mem_rd_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (r_pending),
    .i_data ({r_pend_last, doutb}),
    .i_pop  (w_pop),
    .i_flush(w_flush),
    .o_head (w_fifo_head),
    .o_count(w_fifo_count),
    .o_empty(w_fifo_empty)
  );

  assign addrb   = w_issue ? r_addr : r_addr_hold;
  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign o_valid = !w_fifo_empty;
  assign o_data  = w_fifo_head[DATA_WIDTH-1:0];
  assign o_last  = w_fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_blk_mem_stream_reader.sv
// Scoreboard bench: a RAM model feeds the reader, expected beats are queued per burst.
module tb_blk_mem_stream_reader;

  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int LW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] count;
  logic          abort;
  logic          busy;
  logic          done;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_ready;
  logic          o_last;

  logic [DW-1:0] mem [DEPTH];
  logic [DW:0]   exp_q [$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_beats = 0;
  logic          stab_en = 1'b1;
  logic          prev_stall = 1'b0;
  logic          last_hs = 1'b0;
  logic [DW:0]   prev_word = '0;

  blk_mem_stream_reader #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .count(count),
    .abort(abort), .busy(busy), .done(done), .addrb(addrb), .doutb(doutb),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last)
  );

  always #5 clk = ~clk;

  // Registered-read RAM B-port, no read enable.
  always @(posedge clk) doutb <= mem[addrb];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream for a burst: consecutive words modulo the RAM size, last flag on the final one.
  task automatic push_expected(input int addr, input int cnt);
    for (int i = 0; i < cnt; i++)
      exp_q.push_back({1'b0 | (i == cnt - 1), mem[(addr + i) % DEPTH]});
  endtask

  // Monitor: compares every accepted beat against the scoreboard and checks stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (last_hs) check("done_after_last", {63'd0, done}, 64'd1);
      if (prev_stall && stab_en) begin
        check("stall_valid", {63'd0, o_valid}, 64'd1);
        check("stall_word", {31'd0, o_last, o_data}, {31'd0, prev_word});
      end
      if (o_valid && o_ready) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no beat", {o_last, o_data});
        end else begin
          check("beat", {31'd0, o_last, o_data}, {31'd0, exp_q.pop_front()});
        end
      end
      last_hs    = o_valid && o_ready && o_last;
      prev_stall = o_valid && !o_ready;
      prev_word  = {o_last, o_data};
    end
  end

  // mode 0: o_ready held high (exact timing checked); mode 1: random backpressure.
  task automatic run_burst(input int addr, input int cnt, input int mode);
    int cyc;
    int budget;
    budget = 20 * cnt + 50;
    push_expected(addr, cnt);
    o_ready    = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    start_addr = AW'(addr);
    count      = LW'(cnt);
    start      = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    while (done !== 1'b1 && cyc < budget) begin
      if (mode == 0 && cyc <= cnt)
        check("addrb_seq", {55'd0, addrb}, 64'((addr + cyc - 1) % DEPTH));
      if (cyc == 2) check("no_valid_cycle2", {63'd0, o_valid}, 64'd0);
      if (cyc == 3) check("valid_cycle3", {63'd0, o_valid}, 64'd1);
      if (mode == 1) o_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
    check("busy_at_done", {63'd0, busy}, 64'd0);
    check("all_beats_out", 64'(exp_q.size()), 64'd0);
    if (mode == 0) check("done_cycle", 64'(cyc), 64'(cnt + 3));
    o_ready = 1'b1;
    tick();
    check("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   {63'd0, busy},    64'd0);
    check({tag, "_done"},   {63'd0, done},    64'd0);
    check({tag, "_valid"},  {63'd0, o_valid}, 64'd0);
    check({tag, "_last"},   {63'd0, o_last},  64'd0);
    check({tag, "_addrb"},  {55'd0, addrb},   64'd0);
    check({tag, "_data"},   {32'd0, o_data},  64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int beats0;
    int a;
    for (int i = 0; i < DEPTH; i++) mem[i] = (32'($urandom) << 12) | 32'(i + 'h100);
    rst_n = 1'b0; start = 1'b0; start_addr = '0; count = '0; abort = 1'b0; o_ready = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Basic burst: beats 0x110..0x113 in the low bits.
    run_burst('h010, 4, 0);
    // Backpressure burst.
    run_burst($urandom_range(0, DEPTH - 1), 8, 1);
    // Address wrap at the top of the RAM.
    run_burst(DEPTH - 1, 3, 0);

    // Zero-length request.
    start_addr = AW'('h055); count = '0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done", {63'd0, done}, 64'd1);
    check("zero_busy", {63'd0, busy}, 64'd0);
    check("zero_valid", {63'd0, o_valid}, 64'd0);
    tick();
    check("zero_done_drop", {63'd0, done}, 64'd0);

    // Start while busy is ignored.
    beats0 = n_beats;
    push_expected('h080, 5);
    start_addr = AW'('h080); count = LW'(5); start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start_addr = AW'('h0C0); count = LW'(7); start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && done !== 1'b1; i++) tick();
    check("busy_start_done", {63'd0, done}, 64'd1);
    for (int i = 0; i < 8; i++) tick();
    check("busy_start_beats", 64'(n_beats - beats0), 64'd5);
    check("busy_start_busy", {63'd0, busy}, 64'd0);

    // Abort with a full FIFO.
    a = 'h1A0;
    o_ready = 1'b0;
    start_addr = AW'(a); count = LW'(6); start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_head_valid", {63'd0, o_valid}, 64'd1);
    check("abort_head_word", {31'd0, o_last, o_data}, {32'd0, mem[a]});
    stab_en = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", {63'd0, o_valid}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd1);
    check("abort_busy", {63'd0, busy}, 64'd0);
    o_ready = 1'b1;
    tick();
    check("abort_done_drop", {63'd0, done}, 64'd0);
    @(negedge clk);
    stab_en = 1'b1;
    tick();
    run_burst('h020, 3, 0);

    // Asynchronous reset mid-burst.
    push_expected('h100, 8);
    start_addr = AW'('h100); count = LW'(8); start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    exp_q.delete();
    prev_stall = 1'b0;
    last_hs    = 1'b0;
    rst_n      = 1'b1;
    tick();
    run_burst('h030, 4, 0);

    // Random bursts under random backpressure.
    for (int n = 0; n < 5; n++)
      run_burst($urandom_range(0, DEPTH - 1), $urandom_range(1, 20), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
